// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the uart_mmio register bridge: register map,
// STATUS/CTRL bit positions and the RX/TX sequencer state encodings.
package uart_mmio_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int ST_RX_VALID   = 0;
  localparam int ST_TX_READY   = 1;
  localparam int ST_TX_OVR     = 2;
  localparam int ST_TX_DRAINED = 3;
  localparam int ST_RXFL       = 4;

  localparam int CTRL_OVR_CLR = 0;
  localparam int CTRL_RX_IE   = 1;
  localparam int CTRL_TX_IE   = 2;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_CAPTURE,
    R_GAP
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_PUSH,
    T_GUARD
  } tx_state_t;

endpackage

// File: rtl/uart_rx_prefetch.sv
// RX prefetch engine: pops one byte from the UART RX FIFO into a one-byte
// holding register whenever it is empty, then idles to let stale rxmt settle.
module uart_rx_prefetch
  import uart_mmio_pkg::*;
#(
  parameter int RX_FETCH_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pop,
  input  logic       rxmt,
  input  logic [7:0] q,
  output logic       rd,
  output logic [7:0] hold,
  output logic       valid
);

  rx_state_t  state, next;
  logic [1:0] gap_cnt;
  logic       gap_done;

  assign gap_done = (gap_cnt == 2'(RX_FETCH_GAP - 1));

  always_comb begin
    next = state;
    case (state)
      R_IDLE:    if (!valid && !rxmt) next = R_FETCH;
      R_FETCH:   next = R_CAPTURE;
      R_CAPTURE: next = R_GAP;
      R_GAP:     if (gap_done) next = R_IDLE;
      default:   next = R_IDLE;
    endcase
  end

  // The FIFO samples rd on the falling edge, so q is stable one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= R_IDLE;
      gap_cnt <= '0;
      rd      <= 1'b0;
      hold    <= '0;
      valid   <= 1'b0;
    end else begin
      state   <= next;
      rd      <= (state == R_IDLE) && (next == R_FETCH);
      gap_cnt <= (state == R_GAP) ? gap_cnt + 2'd1 : 2'd0;
      if (state == R_CAPTURE) begin
        hold  <= q;
        valid <= 1'b1;
      end else if (pop) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// CPU register window onto the JTAG UART FIFO port with one-byte TX/RX holding
// registers. Define UART_MMIO_IRQ_EN to build in the interrupt enables and irq_o.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int RX_FETCH_GAP = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cs_i,
  input  logic       we_i,
  input  logic [1:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       irq_o,
  output logic       uart_nwr_o,
  output logic [7:0] uart_data_o,
  output logic       uart_rd_o,
  input  logic [7:0] uart_data_i,
  input  logic       uart_txmt_i,
  input  logic       uart_txfl_i,
  input  logic       uart_rxmt_i,
  input  logic       uart_rxfl_i
);

  tx_state_t  tx_state, tx_next;
  logic [7:0] tx_hold;
  logic       tx_valid, tx_ovr;
  logic       rx_ie, tx_ie;
  logic [7:0] rx_hold;
  logic       rx_valid;
  logic       rd_access, data_wr, ctrl_wr, rx_pop, tx_go, tx_drained;
  logic [7:0] status, ctrl;

  assign rd_access  = cs_i && !we_i;
  assign data_wr    = cs_i && we_i && (addr_i == ADDR_DATA);
  assign ctrl_wr    = cs_i && we_i && (addr_i == ADDR_CTRL);
  assign rx_pop     = rd_access && (addr_i == ADDR_DATA) && rx_valid;
  assign tx_go      = (tx_state == T_IDLE) && tx_valid && !uart_txfl_i;
  assign tx_drained = !tx_valid && (tx_state == T_IDLE) && uart_txmt_i;

  uart_rx_prefetch #(.RX_FETCH_GAP(RX_FETCH_GAP)) u_rx (
    .clk   (clk_i),
    .rst   (rst_i),
    .pop   (rx_pop),
    .rxmt  (uart_rxmt_i),
    .q     (uart_data_i),
    .rd    (uart_rd_o),
    .hold  (rx_hold),
    .valid (rx_valid)
  );

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_IDLE:  if (tx_go) tx_next = T_PUSH;
      T_PUSH:  tx_next = T_GUARD;
      T_GUARD: tx_next = T_IDLE;
      default: tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) tx_state <= T_IDLE;
    else       tx_state <= tx_next;
  end

  // A write landing on the push cycle refills the just-emptied holding register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_hold     <= '0;
      tx_valid    <= 1'b0;
      tx_ovr      <= 1'b0;
      uart_data_o <= '0;
      uart_nwr_o  <= 1'b1;
    end else begin
      uart_nwr_o <= !tx_go;
      if (tx_go) begin
        uart_data_o <= tx_hold;
        tx_valid    <= 1'b0;
      end
      if (data_wr) begin
        if (!tx_valid || tx_go) begin
          tx_hold  <= wdata_i;
          tx_valid <= 1'b1;
        end else begin
          tx_ovr <= 1'b1;
        end
      end
      if (ctrl_wr && wdata_i[CTRL_OVR_CLR]) tx_ovr <= 1'b0;
    end
  end

`ifdef UART_MMIO_IRQ_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        rx_ie <= wdata_i[CTRL_RX_IE];
        tx_ie <= wdata_i[CTRL_TX_IE];
      end
      irq_o <= (rx_ie && rx_valid) || (tx_ie && !tx_valid);
    end
  end
`else
  assign rx_ie = 1'b0;
  assign tx_ie = 1'b0;
  assign irq_o = 1'b0;
`endif

  always_comb begin
    status                = '0;
    status[ST_RX_VALID]   = rx_valid;
    status[ST_TX_READY]   = !tx_valid;
    status[ST_TX_OVR]     = tx_ovr;
    status[ST_TX_DRAINED] = tx_drained;
    status[ST_RXFL]       = uart_rxfl_i;
    ctrl                  = '0;
    ctrl[CTRL_RX_IE]      = rx_ie;
    ctrl[CTRL_TX_IE]      = tx_ie;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else if (rd_access) begin
      case (addr_i)
        ADDR_DATA:   rdata_o <= rx_valid ? rx_hold : 8'h00;
        ADDR_STATUS: rdata_o <= status;
        ADDR_CTRL:   rdata_o <= ctrl;
        default:     rdata_o <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed testbench for uart_mmio: a table of single-cycle vectors for TX push
// and RX prefetch, plus hand-written sequences for overrun, collisions, IRQ and reset.
module tb_uart_mmio;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       cs_i = 1'b0;
  logic       we_i = 1'b0;
  logic [1:0] addr_i = 2'd0;
  logic [7:0] wdata_i = 8'h00;
  logic [7:0] rdata_o;
  logic       irq_o;
  logic       uart_nwr_o;
  logic [7:0] uart_data_o;
  logic       uart_rd_o;
  logic [7:0] uart_data_i = 8'h00;
  logic       uart_txmt_i = 1'b1;
  logic       uart_txfl_i = 1'b0;
  logic       uart_rxmt_i = 1'b1;
  logic       uart_rxfl_i = 1'b0;

  int vec_count = 0;
  int miscompares = 0;

  uart_mmio #(.RX_FETCH_GAP(1)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cs_i        (cs_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .irq_o       (irq_o),
    .uart_nwr_o  (uart_nwr_o),
    .uart_data_o (uart_data_o),
    .uart_rd_o   (uart_rd_o),
    .uart_data_i (uart_data_i),
    .uart_txmt_i (uart_txmt_i),
    .uart_txfl_i (uart_txfl_i),
    .uart_rxmt_i (uart_rxmt_i),
    .uart_rxfl_i (uart_rxfl_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       cs;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       txfl;
    logic       rxmt;
    logic [7:0] q;
    logic       chk_rdata;
    logic [7:0] exp_rdata;
    logic       exp_nwr;
    logic       exp_rd;
    logic [7:0] exp_txdata;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // Drives one register access for one cycle, returning at the next falling edge.
  task automatic applyStimulus(input logic c, input logic w, input logic [1:0] a, input logic [7:0] d);
    cs_i = c;
    we_i = w;
    addr_i = a;
    wdata_i = d;
    @(negedge clk_i);
    cs_i = 1'b0;
    we_i = 1'b0;
  endtask

  task automatic readReg(input string name, input logic [1:0] a, input logic [7:0] exp);
    applyStimulus(1'b1, 1'b0, a, 8'h00);
    checkOutput(name, rdata_o, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 2'd0, 8'h41, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h41};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h41};
    vecs[3]  = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 8'h02, 1'b1, 1'b0, 8'h41};
    vecs[4]  = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 8'h0A, 1'b1, 1'b0, 8'h41};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 8'h41};
    vecs[7]  = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h0A, 1'b1, 1'b0, 8'h41};
    vecs[8]  = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h0B, 1'b1, 1'b0, 8'h41};
    vecs[9]  = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h41};
    vecs[10] = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h0A, 1'b1, 1'b0, 8'h41};
    vecs[11] = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 8'h41};

    idle(3);
    rst_i = 1'b0;
    checkOutput("reset rdata", rdata_o, 8'h00);
    checkOutput("reset nwr", {7'b0, uart_nwr_o}, 8'h01);
    checkOutput("reset rd", {7'b0, uart_rd_o}, 8'h00);
    checkOutput("reset txdata", uart_data_o, 8'h00);
    checkOutput("reset irq", {7'b0, irq_o}, 8'h00);
    readReg("reset status", 2'd1, 8'h0A);

    for (int k = 0; k < 12; k++) begin
      uart_txfl_i = vecs[k].txfl;
      uart_rxmt_i = vecs[k].rxmt;
      uart_data_i = vecs[k].q;
      applyStimulus(vecs[k].cs, vecs[k].we, vecs[k].addr, vecs[k].wdata);
      if (vecs[k].chk_rdata) checkOutput($sformatf("vec%0d rdata", k), rdata_o, vecs[k].exp_rdata);
      checkOutput($sformatf("vec%0d nwr", k), {7'b0, uart_nwr_o}, {7'b0, vecs[k].exp_nwr});
      checkOutput($sformatf("vec%0d rd", k), {7'b0, uart_rd_o}, {7'b0, vecs[k].exp_rd});
      checkOutput($sformatf("vec%0d txdata", k), uart_data_o, vecs[k].exp_txdata);
      checkOutput($sformatf("vec%0d irq", k), {7'b0, irq_o}, 8'h00);
    end

    // TX overrun while the FIFO reports full, then release and clear
    idle(2);
    uart_txfl_i = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h11);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h22);
    checkOutput("ovr nwr held", {7'b0, uart_nwr_o}, 8'h01);
    readReg("ovr status", 2'd1, 8'h04);
    checkOutput("ovr nwr still held", {7'b0, uart_nwr_o}, 8'h01);
    uart_txfl_i = 1'b0;
    begin
      int n = 0;
      while (uart_nwr_o !== 1'b0 && n < 6) begin
        @(negedge clk_i);
        n++;
      end
      checkOutput("ovr release push seen", {7'b0, uart_nwr_o}, 8'h00);
      checkOutput("ovr pushed byte", uart_data_o, 8'h11);
    end
    applyStimulus(1'b1, 1'b1, 2'd2, 8'h01);
    idle(2);
    readReg("ovr cleared status", 2'd1, 8'h0A);

    // DATA write on the T_IDLE -> T_PUSH cycle is accepted
    applyStimulus(1'b1, 1'b1, 2'd0, 8'hA1);
    applyStimulus(1'b1, 1'b1, 2'd0, 8'hB2);
    checkOutput("coll first push", {7'b0, uart_nwr_o}, 8'h00);
    checkOutput("coll first byte", uart_data_o, 8'hA1);
    readReg("coll status", 2'd1, 8'h00);
    idle(1);
    checkOutput("coll guard nwr", {7'b0, uart_nwr_o}, 8'h01);
    idle(1);
    checkOutput("coll second push", {7'b0, uart_nwr_o}, 8'h00);
    checkOutput("coll second byte", uart_data_o, 8'hB2);
    idle(3);
    readReg("coll no overrun", 2'd1, 8'h0A);

    // DATA read on the R_CAPTURE cycle returns 0 and keeps the byte
    uart_rxmt_i = 1'b0;
    uart_data_i = 8'h77;
    idle(1);
    checkOutput("cap rd pulse", {7'b0, uart_rd_o}, 8'h01);
    uart_rxmt_i = 1'b1;
    idle(1);
    readReg("cap read during capture", 2'd0, 8'h00);
    readReg("cap byte retained", 2'd0, 8'h77);
    idle(3);

    // Interrupt on RX byte when rx_ie is set
    applyStimulus(1'b1, 1'b1, 2'd2, 8'h02);
`ifdef UART_MMIO_IRQ_EN
    readReg("irq ctrl read", 2'd2, 8'h02);
`else
    readReg("irq ctrl read", 2'd2, 8'h00);
`endif
    uart_rxmt_i = 1'b0;
    uart_data_i = 8'h33;
    idle(1);
    uart_rxmt_i = 1'b1;
`ifdef UART_MMIO_IRQ_EN
    begin
      int n = 0;
      while (irq_o !== 1'b1 && n < 8) begin
        @(negedge clk_i);
        n++;
      end
      checkOutput("irq rises", {7'b0, irq_o}, 8'h01);
    end
`else
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      checkOutput("irq tied low", {7'b0, irq_o}, 8'h00);
    end
`endif
    readReg("irq data read", 2'd0, 8'h33);
    idle(1);
    checkOutput("irq falls", {7'b0, irq_o}, 8'h00);
    applyStimulus(1'b1, 1'b1, 2'd2, 8'h00);
    idle(3);

    // Reset during T_PUSH
    applyStimulus(1'b1, 1'b1, 2'd0, 8'h55);
    idle(1);
    checkOutput("rst push active", {7'b0, uart_nwr_o}, 8'h00);
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    checkOutput("rst push nwr", {7'b0, uart_nwr_o}, 8'h01);
    checkOutput("rst push rdata", rdata_o, 8'h00);
    checkOutput("rst push txdata", uart_data_o, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checkOutput("rst push no resend", {7'b0, uart_nwr_o}, 8'h01);
    end
    readReg("rst push status", 2'd1, 8'h0A);

    // Reset during R_FETCH discards the popped byte
    uart_rxmt_i = 1'b0;
    uart_data_i = 8'h99;
    idle(1);
    checkOutput("rst fetch active", {7'b0, uart_rd_o}, 8'h01);
    rst_i = 1'b1;
    uart_rxmt_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    checkOutput("rst fetch rd", {7'b0, uart_rd_o}, 8'h00);
    idle(3);
    readReg("rst fetch status", 2'd1, 8'h0A);
    readReg("rst fetch data", 2'd0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
